// File: rtl/filter_lookup_arb_pkg.sv
// Shared filter definitions: lookup FSM encoding,
// header field defaults and a saturating counter helper.
package filter_lookup_arb_pkg;

    localparam int IP_ADDR_LEN_DEF = 32;
    localparam int PORT_LEN_DEF    = 16;
    localparam int STAT_W          = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_RESULT = 2'd2,
        DRAIN       = 2'd3
    } flt_state_e;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v
    );
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/filter_rr_arb.sv
// Round-robin selector: the search starts one past the
// last granted port and wraps around.
module filter_rr_arb #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     index,
    output logic                 found
);

    int         pos;
    logic [IDX_W-1:0] pi;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        pi    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            pos = (int'(last_grant) + k) % NUM_PORTS;
            pi  = IDX_W'(pos);
            if (!found && req[pi]) begin
                found     = 1'b1;
                grant[pi] = 1'b1;
                index     = pi;
            end
        end
    end

endmodule

// File: rtl/filter_lookup_arb.sv
// Shares one header filter engine between several parser
// ports; one lookup in flight, with a result timeout.
module filter_lookup_arb
    import filter_lookup_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int IP_ADDR_LEN    = IP_ADDR_LEN_DEF,
    parameter int PORT_LEN       = PORT_LEN_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic                            arb_enable,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS*IP_ADDR_LEN-1:0] req_src_ip,
    input  logic [NUM_PORTS*IP_ADDR_LEN-1:0] req_dst_ip,
    input  logic [NUM_PORTS*PORT_LEN-1:0]    req_src_port,
    input  logic [NUM_PORTS*PORT_LEN-1:0]    req_dst_port,
    output logic                            hdr_rd,
    output logic                            hdr_clear,
    output logic [IP_ADDR_LEN-1:0]          hdr_src_ip,
    output logic [IP_ADDR_LEN-1:0]          hdr_dst_ip,
    output logic [PORT_LEN-1:0]             hdr_src_port,
    output logic [PORT_LEN-1:0]             hdr_dst_port,
    input  logic                            m_send,
    input  logic                            m_send_rd,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic                            rsp_send,
    output logic                            rsp_timeout,
    output logic [STAT_W-1:0]               cnt_lookups,
    output logic [STAT_W-1:0]               cnt_drops,
    output logic [STAT_W-1:0]               cnt_timeouts
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TMO_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    flt_state_e state_q, state_d;

    logic [IDX_W-1:0]     last_grant_q;
    logic [IDX_W-1:0]     grant_idx_q;
    logic [TMO_W-1:0]     tmo_cnt_q;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_found;

    logic accept;
    logic tmo_hit;
    logic rsp_ok;
    logic rsp_tmo;
    logic rsp_fire;

    logic [IP_ADDR_LEN-1:0] sel_src_ip, sel_dst_ip;
    logic [PORT_LEN-1:0]    sel_src_port, sel_dst_port;

    logic [STAT_W-1:0] lookups_q, drops_q, timeouts_q;

    filter_rr_arb #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .index      (arb_idx),
        .found      (arb_found)
    );

    assign tmo_hit  = (tmo_cnt_q == TMO_LAST);
    assign rsp_fire = rsp_ok | rsp_tmo;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        rsp_ok    = 1'b0;
        rsp_tmo   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_enable) begin
                    req_ready = arb_grant;
                    if (arb_found) begin
                        accept  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                if (m_send_rd) begin
                    rsp_ok  = 1'b1;
                    state_d = DRAIN;
                end else if (tmo_hit) begin
                    rsp_tmo = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // wait for the filter to drop its decision-valid
                if (!m_send_rd || tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            tmo_cnt_q <= '0;
        end else if (state_d != state_q) begin
            tmo_cnt_q <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    always_comb begin
        sel_src_ip   = '0;
        sel_dst_ip   = '0;
        sel_src_port = '0;
        sel_dst_port = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_src_ip   = req_src_ip[i*IP_ADDR_LEN +: IP_ADDR_LEN];
                sel_dst_ip   = req_dst_ip[i*IP_ADDR_LEN +: IP_ADDR_LEN];
                sel_src_port = req_src_port[i*PORT_LEN +: PORT_LEN];
                sel_dst_port = req_dst_port[i*PORT_LEN +: PORT_LEN];
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            grant_idx_q  <= '0;
            hdr_src_ip   <= '0;
            hdr_dst_ip   <= '0;
            hdr_src_port <= '0;
            hdr_dst_port <= '0;
        end else if (accept) begin
            last_grant_q <= arb_idx;
            grant_idx_q  <= arb_idx;
            hdr_src_ip   <= sel_src_ip;
            hdr_dst_ip   <= sel_dst_ip;
            hdr_src_port <= sel_src_port;
            hdr_dst_port <= sel_dst_port;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            hdr_rd      <= 1'b0;
            hdr_clear   <= 1'b0;
            rsp_valid   <= '0;
            rsp_send    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            hdr_rd      <= accept;
            hdr_clear   <= rsp_fire;
            rsp_valid   <= rsp_fire ?
                           (NUM_PORTS'(1) << grant_idx_q) : '0;
            // a timed-out lookup is always reported as a drop
            rsp_send    <= rsp_ok & m_send;
            rsp_timeout <= rsp_tmo;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            lookups_q  <= '0;
            drops_q    <= '0;
            timeouts_q <= '0;
        end else if (rsp_fire) begin
            lookups_q <= sat_inc(lookups_q);
            if (!(rsp_ok && m_send)) begin
                drops_q <= sat_inc(drops_q);
            end
            if (rsp_tmo) begin
                timeouts_q <= sat_inc(timeouts_q);
            end
        end
    end

    assign cnt_lookups  = lookups_q;
    assign cnt_drops    = drops_q;
    assign cnt_timeouts = timeouts_q;

endmodule

// File: tb/tb_filter_lookup_arb.sv
// Directed bench for filter_lookup_arb with a small
// filter-engine model answering two cycles after hdr_rd.
module tb_filter_lookup_arb;

    localparam int NP  = 4;
    localparam int IPW = 32;
    localparam int PW  = 16;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                arb_enable;
    logic [NP-1:0]       req_valid;
    logic [NP-1:0]       req_ready;
    logic [NP*IPW-1:0]   req_src_ip, req_dst_ip;
    logic [NP*PW-1:0]    req_src_port, req_dst_port;
    logic                hdr_rd, hdr_clear;
    logic [IPW-1:0]      hdr_src_ip, hdr_dst_ip;
    logic [PW-1:0]       hdr_src_port, hdr_dst_port;
    logic                m_send, m_send_rd;
    logic [NP-1:0]       rsp_valid;
    logic                rsp_send, rsp_timeout;
    logic [31:0]         cnt_lookups, cnt_drops, cnt_timeouts;

    logic filt_silent;
    logic filt_send;
    assign m_send = filt_send;

    filter_lookup_arb #(
        .NUM_PORTS      (NP),
        .IP_ADDR_LEN    (IPW),
        .PORT_LEN       (PW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .axi_aclk     (clk),
        .axi_aresetn  (rst_n),
        .arb_enable   (arb_enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src_ip   (req_src_ip),
        .req_dst_ip   (req_dst_ip),
        .req_src_port (req_src_port),
        .req_dst_port (req_dst_port),
        .hdr_rd       (hdr_rd),
        .hdr_clear    (hdr_clear),
        .hdr_src_ip   (hdr_src_ip),
        .hdr_dst_ip   (hdr_dst_ip),
        .hdr_src_port (hdr_src_port),
        .hdr_dst_port (hdr_dst_port),
        .m_send       (m_send),
        .m_send_rd    (m_send_rd),
        .rsp_valid    (rsp_valid),
        .rsp_send     (rsp_send),
        .rsp_timeout  (rsp_timeout),
        .cnt_lookups  (cnt_lookups),
        .cnt_drops    (cnt_drops),
        .cnt_timeouts (cnt_timeouts)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          acc_cyc[$];
    int          acc_port[$];
    int          hdr_rd_cyc, hdr_clr_cyc, rsp_cyc, rsp_n;
    logic [IPW-1:0] hdr_src_at_rd;
    logic [NP-1:0]  rsp_vec;
    logic           rsp_snd, rsp_to;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [NP-1:0] v);
        oh2idx = -1;
        for (int i = 0; i < NP; i++) if (v[i]) oh2idx = i;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // filter model: decision-valid high 2..4 cycles after hdr_rd
    int fphase;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fphase = 0;
            m_send_rd = 1'b0;
        end else if (filt_silent) begin
            fphase = 0;
            m_send_rd = 1'b0;
        end else begin
            if (hdr_rd) fphase = 1;
            else if (fphase > 0 && fphase < 6) fphase++;
            else fphase = 0;
            m_send_rd = (fphase >= 3 && fphase <= 5);
        end
    end

    always @(negedge clk) begin
        if (rst_n && |(req_valid & req_ready)) begin
            acc_cyc.push_back(cyc);
            acc_port.push_back(oh2idx(req_ready));
        end
        if (hdr_rd) begin
            hdr_rd_cyc = cyc;
            hdr_src_at_rd = hdr_src_ip;
        end
        if (hdr_clear) hdr_clr_cyc = cyc;
        if (|rsp_valid) begin
            rsp_n++;
            rsp_cyc = cyc;
            rsp_vec = rsp_valid;
            rsp_snd = rsp_send;
            rsp_to  = rsp_timeout;
        end
        if (hdr_rd || hdr_clear)
            chk("rd_clear_exclusive", 64'(hdr_rd & hdr_clear), 0);
    end

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_cyc.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (acc_cyc.size() < n) begin
            failures++;
            $display("FAIL wait_accept actual=%0d required=%0d",
                     acc_cyc.size(), n);
        end
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k = 0;
        while (rsp_n < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (rsp_n < n) begin
            failures++;
            $display("FAIL wait_rsp actual=%0d required=%0d", rsp_n, n);
        end
    endtask

    task automatic clear_log();
        acc_cyc.delete();
        acc_port.delete();
        rsp_n = 0;
        hdr_rd_cyc = -100;
        hdr_clr_cyc = -100;
        rsp_cyc = -100;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        arb_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear_log();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          en;
        logic [NP-1:0] valid;
        logic [NP-1:0] ready;
    } vec_t;

    vec_t tbl[7];
    int   t0, te, nrsp;

    initial begin
        tbl[0] = '{1'b0, 4'b1111, 4'b0000};
        tbl[1] = '{1'b1, 4'b0000, 4'b0000};
        tbl[2] = '{1'b1, 4'b0100, 4'b0100};
        tbl[3] = '{1'b1, 4'b1010, 4'b0010};
        tbl[4] = '{1'b1, 4'b1000, 4'b1000};
        tbl[5] = '{1'b1, 4'b1111, 4'b0001};
        tbl[6] = '{1'b1, 4'b0110, 4'b0010};

        filt_silent = 1'b0;
        filt_send = 1'b1;
        arb_enable = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NP; i++) begin
            req_src_ip[i*IPW +: IPW]  = 32'h0A00_0000 + i;
            req_dst_ip[i*IPW +: IPW]  = 32'hC0A8_0000 + i;
            req_src_port[i*PW +: PW]  = 16'h1000 + 16'(i);
            req_dst_port[i*PW +: PW]  = 16'h0050 + 16'(i);
        end
        clear_log();

        // reset values and combinational grant table
        do_reset();
        @(negedge clk); #1;
        chk("rst_hdr_rd", 64'(hdr_rd), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_cnt_lookups", 64'(cnt_lookups), 0);
        chk("rst_hdr_src_ip", 64'(hdr_src_ip), 0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            arb_enable = tbl[i].en;
            req_valid = tbl[i].valid;
            #1;
            chk($sformatf("tbl_ready_%0d", i), 64'(req_ready),
                64'(tbl[i].ready));
            req_valid = '0;
            arb_enable = 1'b1;
        end

        // single port 2 lookup, filter drops; header latched
        filt_send = 1'b0;
        @(posedge clk); #1;
        req_src_ip[2*IPW +: IPW] = 32'hAAFA_AAAA;
        req_valid = 4'b0100;
        wait_acc(1, 10);
        @(posedge clk); #1;
        req_valid = '0;
        req_src_ip[2*IPW +: IPW] = 32'h0;
        wait_rsp(1, 30);
        t0 = acc_cyc[0];
        chk("p2_port", 64'(acc_port[0]), 2);
        chk("p2_hdr_rd_lat", 64'(hdr_rd_cyc - t0), 1);
        chk("p2_hdr_src", 64'(hdr_src_at_rd), 64'h0000_0000_AAFA_AAAA);
        chk("p2_rsp_lat", 64'(rsp_cyc - t0), 4);
        chk("p2_clr_lat", 64'(hdr_clr_cyc - t0), 4);
        chk("p2_rsp_vec", 64'(rsp_vec), 64'b0100);
        chk("p2_rsp_send", 64'(rsp_snd), 0);
        chk("p2_rsp_to", 64'(rsp_to), 0);
        chk("p2_cnt_drops", 64'(cnt_drops), 1);
        chk("p2_cnt_lookups", 64'(cnt_lookups), 1);
        chk("p2_cnt_timeouts", 64'(cnt_timeouts), 0);

        // all ports busy: round robin order and spacing
        do_reset();
        filt_send = 1'b1;
        req_src_ip[2*IPW +: IPW] = 32'h0A00_0002;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        wait_acc(5, 60);
        chk("rr_lookups", 64'(cnt_lookups), 4);
        chk("rr_last_send", 64'(rsp_snd), 1);
        chk("rr_drops", 64'(cnt_drops), 0);
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_port_%0d", i), 64'(acc_port[i]),
                64'(i % NP));
        for (int i = 1; i < 5; i++)
            chk($sformatf("rr_gap_%0d", i),
                64'(acc_cyc[i] - acc_cyc[i-1]), 7);
        repeat (10) @(posedge clk);

        // silent filter: timeout, then back to IDLE
        do_reset();
        filt_silent = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0010;
        wait_acc(1, 10);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        wait_rsp(1, 40);
        t0 = acc_cyc[0];
        chk("to_rsp_after_rd", 64'(rsp_cyc - hdr_rd_cyc), 17);
        chk("to_rsp_lat", 64'(rsp_cyc - t0), 18);
        chk("to_rsp_vec", 64'(rsp_vec), 64'b0010);
        chk("to_rsp_send", 64'(rsp_snd), 0);
        chk("to_rsp_flag", 64'(rsp_to), 1);
        chk("to_cnt_timeouts", 64'(cnt_timeouts), 1);
        chk("to_cnt_drops", 64'(cnt_drops), 1);
        wait_acc(2, 10);
        chk("to_next_port", 64'(acc_port[1]), 3);
        chk("to_idle_gap", 64'(acc_cyc[1] - rsp_cyc), 1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(2, 40);
        repeat (3) @(posedge clk);

        // reset during WAIT_RESULT abandons the lookup
        do_reset();
        filt_silent = 1'b1;
        req_src_ip[2*IPW +: IPW] = 32'hAAFA_AAAA;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        wait_acc(1, 10);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_hdr_before", 64'(hdr_src_ip), 64'h0000_0000_AAFA_AAAA);
        nrsp = rsp_n;
        rst_n = 1'b0;
        #1;
        chk("mid_hdr_src", 64'(hdr_src_ip), 0);
        chk("mid_hdr_rd", 64'(hdr_rd), 0);
        chk("mid_rsp_valid", 64'(rsp_valid), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_no_rsp", 64'(rsp_n - nrsp), 0);
        clear_log();
        filt_silent = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        wait_acc(1, 10);
        chk("mid_first_port", 64'(acc_port[0]), 0);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (8) @(posedge clk);

        // arb_enable gating, and drop mid-lookup
        do_reset();
        arb_enable = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("en_no_accept", 64'(acc_cyc.size()), 0);
        chk("en_ready_low", 64'(req_ready), 0);
        arb_enable = 1'b1;
        te = cyc;
        #1;
        chk("en_ready_now", 64'(req_ready), 64'b0001);
        wait_acc(1, 5);
        chk("en_accept_cyc", 64'(acc_cyc[0] - te), 0);
        @(posedge clk); #1;
        arb_enable = 1'b0;
        req_valid = '0;
        wait_rsp(1, 20);
        chk("en_rsp_lat", 64'(rsp_cyc - acc_cyc[0]), 4);
        chk("en_rsp_vec", 64'(rsp_vec), 64'b0001);
        arb_enable = 1'b1;
        repeat (5) @(posedge clk);

        // saturating statistics
        do_reset();
        filt_send = 1'b0;
        @(negedge clk);
        force dut.lookups_q  = 32'hFFFF_FFFF;
        force dut.drops_q    = 32'hFFFF_FFFF;
        force dut.timeouts_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.lookups_q;
        release dut.drops_q;
        release dut.timeouts_q;
        @(posedge clk); #1;
        req_valid = 4'b0010;
        wait_acc(1, 10);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(1, 20);
        chk("sat_rsp_send", 64'(rsp_snd), 0);
        chk("sat_lookups", 64'(cnt_lookups), 64'hFFFF_FFFF);
        chk("sat_drops", 64'(cnt_drops), 64'hFFFF_FFFF);
        chk("sat_timeouts", 64'(cnt_timeouts), 64'hFFFF_FFFF);
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_lookup_arb.md
FILTER_LOOKUP_ARB -- requirements
Module: filter_lookup_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of parser requesters sharing one filter engine.
REQ-002 SHALL have parameter IP_ADDR_LEN, default 32: IP address field width.
REQ-003 SHALL have parameter PORT_LEN, default 16: L4 port field width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum wait for filter result.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: ports axi_aclk and axi_aresetn.
REQ-006 axi_aclk  in  1  clock.
REQ-007 axi_aresetn  in  1  async active-low reset.
REQ-008 arb_enable  in  1  grants permitted when high.
REQ-009 req_valid  in  NUM_PORTS  per-port header lookup request.
REQ-010 req_ready  out  NUM_PORTS  one-hot accept; the request is taken when req_valid&req_ready.
REQ-011 req_src_ip, req_dst_ip  in  NUM_PORTS*IP_ADDR_LEN  packed per port, port i at [i*W +: W].
REQ-012 req_src_port, req_dst_port  in  NUM_PORTS*PORT_LEN  packed per port.
REQ-013 hdr_rd, hdr_clear  out  1  registered pulses to filter.
REQ-014 hdr_src_ip, hdr_dst_ip, hdr_src_port, hdr_dst_port  out  widths as above  latched header to filter.
REQ-015 m_send, m_send_rd  in  1  filter decision and decision-valid.
REQ-016 rsp_valid  out  NUM_PORTS  one-cycle one-hot result pulse.
REQ-017 rsp_send, rsp_timeout  out  1  decision and timeout flag, qualified by rsp_valid.
REQ-018 cnt_lookups, cnt_drops, cnt_timeouts  out  32  statistics for the register block.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_RESULT, DRAIN.
REQ-020 IDLE: req_ready is high only for the round-robin winner among req_valid, and only if arb_enable is high; it is combinational from state, req_valid, and the pointer.
REQ-021 Round-robin search SHALL start at (last_grant+1) mod NUM_PORTS; last_grant updates on accept.
REQ-022 On accept, the block SHALL latch the winner's header onto hdr_* and the grant index, and go to ISSUE; hdr_* hold until the next accept.
REQ-023 ISSUE: hdr_rd SHALL be high for exactly that one cycle, then the FSM goes to WAIT_RESULT with the counter cleared.
REQ-024 WAIT_RESULT: when m_send_rd is sampled high, the next cycle SHALL have rsp_valid[grant]=1, rsp_send=m_send, rsp_timeout=0, and hdr_clear=1 for one cycle, with the FSM going to DRAIN.
REQ-025 WAIT_RESULT timeout: if the counter reaches TIMEOUT_CYCLES-1 without m_send_rd, the next cycle SHALL have rsp_valid[grant]=1, rsp_send=0 (fail-safe drop), rsp_timeout=1, and hdr_clear=1, with the FSM going to DRAIN.
REQ-026 DRAIN: the FSM SHALL go to IDLE when m_send_rd is sampled low or the counter reaches TIMEOUT_CYCLES-1; no grant is given in DRAIN.
REQ-027 With a compliant filter, if accept is at cycle T: hdr_rd at T+1, rsp_valid at T+4, hdr_clear at T+4, IDLE at T+7.
REQ-028 Only one lookup SHALL be outstanding; requests arriving while busy are held by req_ready=0 and never dropped.
REQ-029 The block SHALL ignore req_valid deassertion after accept; the latched header is used.
REQ-030 Each response SHALL increment cnt_lookups; rsp_send=0 increments cnt_drops (timeouts included); a timeout increments cnt_timeouts. All counters saturate at 32'hFFFFFFFF.
REQ-031 If arb_enable falls mid-lookup, the lookup SHALL complete normally.
REQ-032 hdr_rd and hdr_clear SHALL never be high in the same cycle.

Reset
REQ-033 While axi_aresetn is low the block SHALL asynchronously clear: state=IDLE, last_grant=NUM_PORTS-1 (port 0 first), hdr_rd=hdr_clear=0, hdr_* =0, rsp_valid=0, rsp_send=0, rsp_timeout=0, counters=0.
REQ-034 Reset mid-lookup SHALL abandon it with no rsp_valid; the filter shares the same reset.

Structure
REQ-035 FSM encodings and the IP_ADDR_LEN/PORT_LEN defaults SHALL live in the shared filter definitions package/header.
REQ-036 Round-robin selection SHALL be a sub-module filter_rr_arb (inputs req, last_grant; outputs one-hot grant, index).

Verification
REQ-037 Port 2 only valid, header src_ip=0xAAFAAAAA, filter returns m_send=0 -> hdr_rd at T+1 with that header, rsp_valid=4'b0100 at T+4 with rsp_send=0, cnt_drops=1.
REQ-038 All four ports valid continuously, after reset -> grant order 0,1,2,3,0; accepts spaced 7 cycles apart.
REQ-039 Filter model never asserts m_send_rd, TIMEOUT_CYCLES=16 -> rsp_valid 17 cycles after hdr_rd with rsp_send=0 and rsp_timeout=1, cnt_timeouts=1, return to IDLE.
REQ-040 axi_aresetn low during WAIT_RESULT -> no rsp_valid, all outputs zero immediately, port 0 granted first after release.
REQ-041 arb_enable=0 with req_valid=4'b1111 -> req_ready stays 0; raise arb_enable -> port 0 accepted same cycle.
REQ-042 Counters preset to 32'hFFFFFFFF by force, then one drop response -> all counters remain 32'hFFFFFFFF.
